// File: rtl/cache_control_nway_pkg.sv
// Shared types for the N-way cache controller and its helpers.
//   cache_ctl_state_t : controller FSM encoding
//   MIN_WAYS/MAX_WAYS : legal range for the way-count parameter
package cache_control_nway_pkg;

    localparam int MIN_WAYS = 2;
    localparam int MAX_WAYS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        WB_BREAK  = 2'd2,
        FILL      = 2'd3
    } cache_ctl_state_t;

endpackage

// File: rtl/cache_control_nway_if.sv
// Bundle between the cache controller and its surroundings (CPU request,
// datapath set state, memory port, performance counters).
//   master : CPU/datapath/memory side, drives requests and set state
//   slave  : the controller, drives datapath controls and counters
interface cache_control_nway_if #(
    parameter int NUM_WAYS  = 4,
    parameter int CNT_WIDTH = 32
);
    localparam int WAY_IDX_W = $clog2(NUM_WAYS);

    logic                 cache_read;
    logic                 cache_write;
    logic [NUM_WAYS-1:0]  way_hit;
    logic [NUM_WAYS-1:0]  way_valid;
    logic [NUM_WAYS-1:0]  way_dirty;
    logic [NUM_WAYS-2:0]  plru_out;
    logic                 mem_resp;
    logic                 perf_clear;

    logic                 cache_resp;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_addr_sel;
    logic                 data_sel;
    logic [NUM_WAYS-1:0]  load_data;
    logic [NUM_WAYS-1:0]  load_tag;
    logic [NUM_WAYS-1:0]  load_dirty;
    logic                 dirty_in;
    logic                 load_plru;
    logic [NUM_WAYS-2:0]  plru_in;
    logic [WAY_IDX_W-1:0] victim_way;
    logic [CNT_WIDTH-1:0] hit_count;
    logic [CNT_WIDTH-1:0] miss_count;
    logic [CNT_WIDTH-1:0] wb_count;

    modport master (
        output cache_read, cache_write, way_hit, way_valid, way_dirty,
               plru_out, mem_resp, perf_clear,
        input  cache_resp, mem_read, mem_write, mem_addr_sel, data_sel,
               load_data, load_tag, load_dirty, dirty_in, load_plru,
               plru_in, victim_way, hit_count, miss_count, wb_count
    );

    modport slave (
        input  cache_read, cache_write, way_hit, way_valid, way_dirty,
               plru_out, mem_resp, perf_clear,
        output cache_resp, mem_read, mem_write, mem_addr_sel, data_sel,
               load_data, load_tag, load_dirty, dirty_in, load_plru,
               plru_in, victim_way, hit_count, miss_count, wb_count
    );

endinterface

// File: rtl/cache_control_nway_plru_tree.sv
// Combinational tree pseudo-LRU helper.
//   plru_bits  : tree bits of a set (node i has children 2i+1, 2i+2)
//   access_way : way being accessed
//   victim     : way the tree currently points at
//   plru_next  : tree bits after an access to access_way
// A node bit of 0 means the victim lies in the lower-index subtree.
module plru_tree #(
    parameter  int NUM_WAYS  = 4,
    localparam int WAY_IDX_W = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0]  plru_bits,
    input  logic [WAY_IDX_W-1:0] access_way,
    output logic [WAY_IDX_W-1:0] victim,
    output logic [NUM_WAYS-2:0]  plru_next
);

    localparam logic [NUM_WAYS-2:0] NODE_ONE = (NUM_WAYS-1)'(1);

    always_comb begin : walk_victim
        int                  node;
        logic [NUM_WAYS-2:0] sh;
        node = 0;
        sh   = '0;
        for (int lvl = 0; lvl < WAY_IDX_W; lvl++) begin
            sh   = plru_bits >> node;
            node = 2 * node + (sh[0] ? 2 : 1);
        end
        victim = WAY_IDX_W'(node - (NUM_WAYS - 1));
    end

    // Walk the access path from the root, pointing each node away from
    // the accessed way; MSB of the way index picks the root's child.
    always_comb begin : walk_update
        int                   node;
        logic [WAY_IDX_W-1:0] aw;
        node      = 0;
        aw        = '0;
        plru_next = plru_bits;
        for (int lvl = 0; lvl < WAY_IDX_W; lvl++) begin
            aw        = access_way >> (WAY_IDX_W - 1 - lvl);
            plru_next = (plru_next & ~(NODE_ONE << node))
                      | (aw[0] ? '0 : (NODE_ONE << node));
            node      = 2 * node + (aw[0] ? 2 : 1);
        end
    end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back/write-allocate cache.
//   clk, rst : clock, synchronous active-high reset
//   bus      : CPU request, datapath set state and controls, memory port,
//              saturating hit/miss/writeback counters
//
// state     | meaning
// IDLE      | wait for request; hits complete here in zero wait states
// WRITEBACK | write dirty victim line to memory
// WB_BREAK  | one dead cycle between writeback and fill
// FILL      | read line from memory into victim way
module cache_control_nway
    import cache_control_nway_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int CNT_WIDTH = 32,
    parameter int WAY_IDX_W = $clog2(NUM_WAYS)
) (
    input logic               clk,
    input logic               rst,
    cache_control_nway_if.slave bus
);

    if (NUM_WAYS < MIN_WAYS || NUM_WAYS > MAX_WAYS ||
        (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
        $error("cache_control_nway: NUM_WAYS must be a power of two in 2..8");
    end

    cache_ctl_state_t     state, state_next;
    logic                 req, hit, miss, hit_resp, miss_pending;
    logic [WAY_IDX_W-1:0] hit_way, inv_way, plru_victim, victim_comb, victim_q;
    logic [NUM_WAYS-2:0]  plru_next;
    logic [CNT_WIDTH-1:0] hit_cnt, miss_cnt, wb_cnt;

    assign req      = bus.cache_read | bus.cache_write;
    assign hit      = req & (|bus.way_hit);
    assign miss     = (state == IDLE) & req & ~hit;
    assign hit_resp = (state == IDLE) & hit;

    // Lowest set bit wins for both the hit way and the first invalid way.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (bus.way_hit[i])    hit_way = WAY_IDX_W'(i);
            if (!bus.way_valid[i]) inv_way = WAY_IDX_W'(i);
        end
    end

    assign victim_comb = (~&bus.way_valid) ? inv_way : plru_victim;

    plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
        .plru_bits (bus.plru_out),
        .access_way(hit_way),
        .victim    (plru_victim),
        .plru_next (plru_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (miss)
                           state_next = (bus.way_valid[victim_comb] & bus.way_dirty[victim_comb])
                                      ? WRITEBACK : FILL;
            WRITEBACK: if (bus.mem_resp) state_next = WB_BREAK;
            WB_BREAK:  state_next = FILL;
            FILL:      if (bus.mem_resp) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cache_resp   = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.data_sel     = 1'b0;
        bus.load_data    = '0;
        bus.load_tag     = '0;
        bus.load_dirty   = '0;
        bus.dirty_in     = 1'b0;
        bus.load_plru    = 1'b0;
        bus.plru_in      = '0;
        unique case (state)
            IDLE: if (hit) begin
                bus.cache_resp = 1'b1;
                bus.load_plru  = 1'b1;
                bus.plru_in    = plru_next;
                if (bus.cache_write) begin
                    bus.data_sel   = 1'b1;
                    bus.load_data  = NUM_WAYS'(1) << hit_way;
                    bus.load_dirty = NUM_WAYS'(1) << hit_way;
                    bus.dirty_in   = 1'b1;
                end
            end
            WRITEBACK: begin
                bus.mem_write    = 1'b1;
                bus.mem_addr_sel = 1'b1;
            end
            WB_BREAK: ;
            FILL: begin
                bus.mem_read = 1'b1;
                if (bus.mem_resp) begin
                    bus.load_data  = NUM_WAYS'(1) << victim_q;
                    bus.load_tag   = NUM_WAYS'(1) << victim_q;
                    bus.load_dirty = NUM_WAYS'(1) << victim_q;
                end
            end
            default: ;
        endcase
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic inc);
        return (inc && cnt != '1) ? cnt + 1'b1 : cnt;
    endfunction

    // The response that ends a miss is the replayed hit, so it is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            victim_q     <= '0;
            miss_pending <= 1'b0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            wb_cnt       <= '0;
        end else begin
            if (miss) begin
                victim_q     <= victim_comb;
                miss_pending <= 1'b1;
            end else if (hit_resp) begin
                miss_pending <= 1'b0;
            end
            if (bus.perf_clear) begin
                hit_cnt  <= '0;
                miss_cnt <= '0;
                wb_cnt   <= '0;
            end else begin
                hit_cnt  <= sat_inc(hit_cnt, hit_resp & ~miss_pending);
                miss_cnt <= sat_inc(miss_cnt, miss);
                wb_cnt   <= sat_inc(wb_cnt, (state == WRITEBACK) & bus.mem_resp);
            end
        end
    end

    assign bus.victim_way = victim_q;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
    assign bus.wb_count   = wb_cnt;

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.cache_read && bus.cache_write));
    a_hit_onehot: assert property (@(posedge clk) disable iff (rst)
        req |-> $onehot0(bus.way_hit));

endmodule

// File: tb/tb_cache_control_nway.sv
module tb_cache_control_nway;

    localparam int NW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [NW-1:0] load_data;
        logic [NW-1:0] load_dirty;
        logic          dirty_in;
        logic [NW-2:0] plru_in;
        logic          load_plru;
    } resp_t;

    logic  clk, rst;
    int    checks = 0;
    int    failures = 0;
    resp_t sb[$];

    cache_control_nway_if #(.NUM_WAYS(NW), .CNT_WIDTH(CW)) bus ();

    cache_control_nway #(.NUM_WAYS(NW), .CNT_WIDTH(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand-derived PLRU updates starting from tree bits 3'b000.
    function automatic logic [2:0] plru_from_zero(input int w);
        case (w)
            0:       return 3'b011;
            1:       return 3'b001;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.cache_resp) begin
            resp_t act, exp;
            act = '{bus.load_data, bus.load_dirty, bus.dirty_in, bus.plru_in, bus.load_plru};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got %h expected no response", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL resp: got ld=%b ldirty=%b din=%b plru=%b lp=%b expected ld=%b ldirty=%b din=%b plru=%b lp=%b",
                             act.load_data, act.load_dirty, act.dirty_in, act.plru_in, act.load_plru,
                             exp.load_data, exp.load_dirty, exp.dirty_in, exp.plru_in, exp.load_plru);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.cache_read  = 1'b0;
        bus.cache_write = 1'b0;
        bus.way_hit     = '0;
        bus.way_valid   = '0;
        bus.way_dirty   = '0;
        bus.plru_out    = '0;
        bus.mem_resp    = 1'b0;
        bus.perf_clear  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();

        // reset state
        check("rst_resp",   32'(bus.cache_resp), 0);
        check("rst_mem",    32'({bus.mem_read, bus.mem_write, bus.mem_addr_sel}), 0);
        check("rst_victim", 32'(bus.victim_way), 0);
        check("rst_cnt",    32'({bus.hit_count, bus.miss_count, bus.wb_count}), 0);
        check("rst_plru",   32'({bus.load_plru, bus.plru_in}), 0);

        // clean read miss, all valid, plru 000 -> way0
        bus.way_valid = 4'hF;
        bus.plru_out  = 3'b000;
        bus.cache_read = 1'b1;
        tick();
        check("t1_victim", 32'(bus.victim_way), 0);
        check("t1_fill",   32'({bus.mem_read, bus.mem_write, bus.mem_addr_sel}), 'b100);
        check("t1_miss",   32'(bus.miss_count), 1);
        tick();
        tick();
        bus.mem_resp = 1'b1;
        settle();
        check("t1_ld",   32'(bus.load_data), 'b0001);
        check("t1_ltag", 32'(bus.load_tag), 'b0001);
        check("t1_din",  32'({bus.data_sel, bus.dirty_in}), 0);
        sb.push_back('{4'b0000, 4'b0000, 1'b0, 3'b011, 1'b1});
        tick();
        bus.mem_resp = 1'b0;
        bus.way_hit  = 4'b0001;
        settle();
        check("t1_resp", 32'(bus.cache_resp), 1);
        tick();
        bus.cache_read = 1'b0;
        bus.way_hit    = '0;
        bus.plru_out   = 3'b011;
        settle();
        check("t1_hitcnt",  32'(bus.hit_count), 0);
        check("t1_misscnt", 32'(bus.miss_count), 1);

        // invalid way first: way2 chosen despite plru pointing elsewhere
        bus.way_valid  = 4'b1011;
        bus.plru_out   = 3'b000;
        bus.cache_read = 1'b1;
        tick();
        check("t2_victim", 32'(bus.victim_way), 2);
        check("t2_fill",   32'({bus.mem_read, bus.mem_write}), 'b10);
        bus.mem_resp = 1'b1;
        settle();
        check("t2_ltag", 32'(bus.load_tag), 'b0100);
        sb.push_back('{4'b0000, 4'b0000, 1'b0, 3'b100, 1'b1});
        tick();
        bus.mem_resp  = 1'b0;
        bus.way_valid = 4'hF;
        bus.way_hit   = 4'b0100;
        tick();
        bus.cache_read = 1'b0;
        bus.way_hit    = '0;
        settle();
        check("t2_misscnt", 32'(bus.miss_count), 2);

        // dirty victim way3, write miss: WRITEBACK, WB_BREAK, FILL, hit
        bus.way_dirty   = 4'b1000;
        bus.plru_out    = 3'b101;
        bus.cache_write = 1'b1;
        settle();
        check("t3_idle_mw", 32'(bus.mem_write), 0);
        tick();
        check("t3_wb",        32'({bus.mem_read, bus.mem_write, bus.mem_addr_sel}), 'b011);
        check("t3_victim",    32'(bus.victim_way), 3);
        tick();
        bus.mem_resp = 1'b1;
        settle();
        check("t3_wb_hold", 32'(bus.mem_write), 1);
        tick();
        bus.mem_resp = 1'b0;
        settle();
        check("t3_break", 32'({bus.mem_read, bus.mem_write, bus.mem_addr_sel, bus.load_data, bus.cache_resp}), 0);
        check("t3_wbcnt", 32'(bus.wb_count), 1);
        tick();
        check("t3_fill", 32'({bus.mem_read, bus.mem_write, bus.mem_addr_sel}), 'b100);
        bus.mem_resp = 1'b1;
        settle();
        check("t3_fill_ld", 32'({bus.load_data, bus.load_dirty, bus.dirty_in}), 'b1000_1000_0);
        sb.push_back('{4'b1000, 4'b1000, 1'b1, 3'b000, 1'b1});
        tick();
        bus.mem_resp  = 1'b0;
        bus.way_dirty = '0;
        bus.way_hit   = 4'b1000;
        settle();
        check("t3_dsel", 32'(bus.data_sel), 1);
        tick();
        bus.cache_write = 1'b0;
        bus.way_hit     = '0;
        settle();
        check("t3_cnt", 32'({bus.wb_count, bus.miss_count, bus.hit_count}), 'h130);

        // write hit way1, plru 000
        bus.plru_out    = 3'b000;
        bus.way_hit     = 4'b0010;
        bus.cache_write = 1'b1;
        sb.push_back('{4'b0010, 4'b0010, 1'b1, 3'b001, 1'b1});
        settle();
        check("t4_dsel", 32'(bus.data_sel), 1);
        tick();
        bus.cache_write = 1'b0;
        // read hit way2, plru 111
        bus.plru_out   = 3'b111;
        bus.way_hit    = 4'b0100;
        bus.cache_read = 1'b1;
        sb.push_back('{4'b0000, 4'b0000, 1'b0, 3'b110, 1'b1});
        tick();
        bus.cache_read = 1'b0;
        bus.way_hit    = '0;
        settle();
        check("t4_hitcnt", 32'(bus.hit_count), 2);

        // stray mem_resp in IDLE is ignored
        bus.mem_resp = 1'b1;
        settle();
        check("t5_stray_out", 32'({bus.mem_read, bus.mem_write, bus.load_data, bus.load_tag}), 0);
        tick();
        bus.mem_resp = 1'b0;
        settle();
        check("t5_stray_cnt", 32'({bus.wb_count, bus.miss_count}), 'h13);

        // reset in second FILL cycle
        bus.plru_out   = 3'b000;
        bus.cache_read = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.cache_read = 1'b0;
        settle();
        check("t6_mem",    32'({bus.mem_read, bus.mem_write}), 0);
        check("t6_cnt",    32'({bus.hit_count, bus.miss_count, bus.wb_count}), 0);
        check("t6_victim", 32'(bus.victim_way), 0);

        // hit counter saturation and perf_clear priority
        bus.cache_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.way_hit = 4'(1 << (i % 4));
            sb.push_back('{4'b0000, 4'b0000, 1'b0, plru_from_zero(i % 4), 1'b1});
            tick();
            if (i == 14) check("t7_hit15", 32'(bus.hit_count), 'hF);
        end
        check("t7_sat", 32'(bus.hit_count), 'hF);
        bus.way_hit    = 4'b0001;
        bus.perf_clear = 1'b1;
        sb.push_back('{4'b0000, 4'b0000, 1'b0, 3'b011, 1'b1});
        tick();
        bus.perf_clear = 1'b0;
        bus.cache_read = 1'b0;
        bus.way_hit    = '0;
        settle();
        check("t7_clear", 32'(bus.hit_count), 0);

        tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_control_nway.md
Name: cache_control_nway

Overview:
- Control FSM for an N-way set-associative, write-back, write-allocate cache. It generalises the two-way controller with these additions:
  - parametrised way count;
  - tree pseudo-LRU replacement;
  - invalid-way-first victim selection;
  - a registered victim index;
  - saturating hit/miss/writeback performance counters with clear.
- Sits between the CPU-side request interface and the cache datapath, which holds the tag/valid/dirty/PLRU arrays, and the physical memory port.

Parameters:
- NUM_WAYS, 4, way count; power of two, 2..8.
- CNT_WIDTH, 32, width of each performance counter.
- WAY_IDX_W, $clog2(NUM_WAYS), victim index width; derived, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cache_read  in  1  CPU read request; held until cache_resp
- cache_write  in  1  CPU write request; held until cache_resp
- way_hit  in  NUM_WAYS  per-way tag match AND valid, for the indexed set
- way_valid  in  NUM_WAYS  valid bits of the indexed set
- way_dirty  in  NUM_WAYS  dirty bits of the indexed set
- plru_out  in  NUM_WAYS-1  PLRU tree bits of the indexed set
- mem_resp  in  1  memory completion strobe
- perf_clear  in  1  zero all counters
- cache_resp  out  1  request complete
- mem_read  out  1  memory line read
- mem_write  out  1  memory line write
- mem_addr_sel  out  1  1 = victim tag/set address, 0 = CPU address
- data_sel  out  1  1 = write CPU data into line, 0 = memory line
- load_data  out  NUM_WAYS  one-hot data array write enable
- load_tag  out  NUM_WAYS  one-hot tag + valid write enable
- load_dirty  out  NUM_WAYS  one-hot dirty write enable
- dirty_in  out  1  dirty value written
- load_plru  out  1  PLRU array write enable
- plru_in  out  NUM_WAYS-1  new PLRU bits
- victim_way  out  WAY_IDX_W  registered victim index
- hit_count  out  CNT_WIDTH  request-count registers
- miss_count  out  CNT_WIDTH  request-count registers
- wb_count  out  CNT_WIDTH  request-count registers

Behaviour:
- Reset:
  - state = IDLE; victim_way = 0; miss_pending = 0; all counters = 0.
  - All combinational outputs are 0 in IDLE with no request.
  - rst asserted in any state aborts the operation. mem_read and mem_write are 0 from the cycle after the reset edge.
- req = cache_read | cache_write. cache_read and cache_write both high is illegal; flag it with an assertion.
- hit = req & |way_hit.
  - Hit way = lowest set bit of way_hit.
  - More than one bit set is illegal (assertion).
- IDLE, read hit:
  - Same cycle: cache_resp = 1, load_plru = 1, plru_in = PLRU update for the hit way.
  - Zero-wait hit latency.
- IDLE, write hit:
  - Also assert data_sel = 1, load_data[hit] = 1, load_dirty[hit] = 1, dirty_in = 1.
- IDLE, miss (req & ~hit):
  - Register victim_way, miss_pending <= 1, miss_count++.
  - Next state is WRITEBACK if way_valid[v] & way_dirty[v], else FILL. Here v is the combinational victim.
- Victim selection: lowest-indexed invalid way if any; otherwise the PLRU victim.
- PLRU tree:
  - Node i has children 2i+1 and 2i+2; leaves are ways in ascending order.
  - Bit 0 means the victim lies in the lower-index subtree.
  - An access to way w sets every node on its path to point away from w. Nodes off the path are unchanged.
- WRITEBACK:
  - mem_write = 1, mem_addr_sel = 1.
  - On mem_resp: wb_count++, next state WB_BREAK.
- WB_BREAK:
  - One idle cycle, all outputs 0. Next state FILL.
- FILL:
  - mem_read = 1, mem_addr_sel = 0.
  - On mem_resp: load_data, load_tag and load_dirty for victim_way, with data_sel = 0 and dirty_in = 0. Next state IDLE.
  - The held request then hits in IDLE, so miss latency = memory cycles + 1.
- Counting:
  - hit_count increments on a hit response only when miss_pending = 0.
  - A response with miss_pending = 1 clears miss_pending and does not count.
  - Counters saturate at all-ones.
  - perf_clear has priority over any same-cycle increment.
- mem_resp outside WRITEBACK/FILL is ignored.
- Requests withdrawn mid-miss are illegal. The FSM still completes the fill.

Decomposition:
- Shared lc3b_types package gets:
  - the cache_ctl_state_t enum {IDLE, WRITEBACK, WB_BREAK, FILL};
  - the way-count bound constant.
- Sub-module plru_tree (combinational, parametrised NUM_WAYS), providing:
  - victim index from plru bits;
  - updated plru bits from an accessed way.
- It is reused by the future L2.

Test Plan:
- NUM_WAYS=4, all valid and clean, plru_out=3'b000, read miss, mem_resp after 3 cycles:
  - victim_way=0 and load_data=4'b0001 on the mem_resp cycle.
  - The next cycle hits way0 with cache_resp=1 and plru_in=3'b011.
  - miss_count=1, hit_count=0.
- way_valid=4'b1011, read miss -> victim_way=2 regardless of plru_out, then FILL.
- Dirty victim (plru_out=3'b101 -> way3, way_dirty[3]=1), write miss -> exact state sequence:
  - WRITEBACK with mem_write and mem_addr_sel=1;
  - WB_BREAK for 1 cycle;
  - FILL;
  - write hit with load_dirty=4'b1000, dirty_in=1.
  - Counters afterwards: wb_count=1, miss_count=1.
- Write hit on way1 with plru_out=3'b000 -> same-cycle cache_resp, load_data=4'b0010, plru_in=3'b001, hit_count+1.
- rst pulsed in the second FILL cycle -> IDLE on the next edge, mem_read=0, counters=0.
- hit_count preset to all-ones via a force, then a hit -> stays all-ones. perf_clear together with a hit -> 0.
